// File: rtl/mem_responder.sv
// Single-outstanding memory target: latches one request, waits WAIT_CYCLES, then responds.
// Define MEM_RESPONDER_BYTE_EN_EN to add req_wstrb byte-lane write strobes.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef MEM_RESPONDER_BYTE_EN_EN
    input  logic [3:0]  req_wstrb,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] idx_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic [ADDR_W-1:0] req_idx;
    logic [1:0]        req_off;
    logic              range_err;
    logic              align_err;
    logic              req_err_d;
    logic              accept;
    logic              wr_en;
    logic [3:0]        wstrb_eff;
    logic [ADDR_W-1:0] rd_idx;
    logic [31:0]       mem_rd;

    assign req_idx   = req_addr[ADDR_W+1:2];
    assign req_off   = req_addr[1:0];
    assign range_err = (req_addr >> (ADDR_W + 2)) != 32'd0;

`ifdef MEM_RESPONDER_BYTE_EN_EN
    logic strobe_ok;

    // A lane group may be addressed either word-aligned or at its own first byte.
    always_comb begin
        strobe_ok = 1'b0;
        case (req_wstrb)
            4'b0000: strobe_ok = 1'b1;
            4'b1111: strobe_ok = (req_off == 2'd0);
            4'b0011: strobe_ok = (req_off == 2'd0);
            4'b1100: strobe_ok = (req_off == 2'd0) || (req_off == 2'd2);
            4'b0001: strobe_ok = (req_off == 2'd0);
            4'b0010: strobe_ok = (req_off == 2'd0) || (req_off == 2'd1);
            4'b0100: strobe_ok = (req_off == 2'd0) || (req_off == 2'd2);
            4'b1000: strobe_ok = (req_off == 2'd0) || (req_off == 2'd3);
            default: strobe_ok = 1'b0;
        endcase
    end

    assign align_err = req_we ? !strobe_ok : (req_off != 2'd0);
    assign wstrb_eff = req_wstrb;
`else
    assign align_err = (req_off != 2'd0);
    assign wstrb_eff = 4'hF;
`endif

    assign req_err_d = align_err | range_err;
    assign accept    = (state_q == S_IDLE) && req_valid;
    assign wr_en     = accept && req_we && !req_err_d;

    // With zero wait states the read happens on the acceptance edge itself.
    assign rd_idx = (state_q == S_IDLE) ? req_idx : idx_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en && wstrb_eff[gi]) begin
                    lane_mem[req_idx] <= req_wdata[gi*8 +: 8];
                end
            end

            assign mem_rd[gi*8 +: 8] = lane_mem[rd_idx];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        we_q        <= req_we;
                        err_q       <= req_err_d;
                        idx_q       <= req_idx;
                        req_ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= req_err_d;
                            rsp_rdata_q <= (req_we || req_err_d) ? 32'd0 : mem_rd;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                        rsp_rdata_q <= (we_q || err_q) ? 32'd0 : mem_rd;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with 2 wait states, one with 0, against a word-array model.
// Byte-strobe scenarios are included when MEM_RESPONDER_BYTE_EN_EN is defined.
module tb_mem_responder;

    localparam int ADDR_W = 8;
    localparam int NWORDS = 1 << ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
`ifdef MEM_RESPONDER_BYTE_EN_EN
    logic [3:0]  req_wstrb [2];
`endif

    mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dut_w2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_we    (req_we[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
`ifdef MEM_RESPONDER_BYTE_EN_EN
        .req_wstrb (req_wstrb[0]),
`endif
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0])
    );

    mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut_w0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_we    (req_we[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
`ifdef MEM_RESPONDER_BYTE_EN_EN
        .req_wstrb (req_wstrb[1]),
`endif
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1])
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          waits [2] = '{2, 0};
    logic [31:0] mdl   [2][NWORDS];
    bit          known [2][NWORDS];
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Error rule written from the address map: lane group must be contiguous, naturally
    // aligned, and addressed at offset 0 or at its first lane.
    function automatic bit exp_err(input bit we, input logic [31:0] a, input logic [3:0] s);
        bit mis;
        int lo;
        int n;
        logic [3:0] pat;
        mis = (a[1:0] != 2'd0);
`ifdef MEM_RESPONDER_BYTE_EN_EN
        if (we) begin
            lo = -1;
            n  = 0;
            for (int b = 0; b < 4; b++) begin
                if (s[b]) begin
                    if (lo < 0) lo = b;
                    n++;
                end
            end
            if (n == 0) begin
                mis = 1'b0;
            end else begin
                pat = 4'(((1 << n) - 1) << lo);
                mis = !((n != 3) && (pat == s) && (lo % n == 0) &&
                        (a[1:0] == 2'd0 || int'(a[1:0]) == lo));
            end
        end
`else
        if (we && s == 4'h0) mis = mis;
`endif
        return mis || (a >= (32'd1 << (ADDR_W + 2)));
    endfunction

    // Drive a stray request while the responder is busy; it must be ignored.
    task automatic garbage(input int d);
        req_valid[d] = 1'($urandom_range(0, 1));
        req_we[d]    = 1'b1;
        req_addr[d]  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        req_wdata[d] = $urandom;
`ifdef MEM_RESPONDER_BYTE_EN_EN
        req_wstrb[d] = 4'hF;
`endif
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic txn(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s_in, input int hold, input string tag);
        logic [3:0]  s;
        logic [31:0] exp_rd;
        logic [31:0] rd0;
        bit          e;
        bit          known_rd;
        int          idx;
        int          lat;
        s = s_in;
`ifndef MEM_RESPONDER_BYTE_EN_EN
        s = 4'hF;
`endif
        idx      = int'(a[ADDR_W+1:2]);
        e        = exp_err(we, a, s);
        known_rd = 1'b1;
        exp_rd   = 32'd0;
        if (!we && !e) begin
            known_rd = known[d][idx];
            exp_rd   = mdl[d][idx];
        end
        if (we && !e) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[d][idx][b*8 +: 8] = wd[b*8 +: 8];
            if (s == 4'hF) known[d][idx] = 1'b1;
        end

        check({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = wd;
`ifdef MEM_RESPONDER_BYTE_EN_EN
        req_wstrb[d] = s;
`endif
        @(negedge clk);
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            check({tag, "_busy_ready"}, 32'(req_ready[d]), 32'd0);
            garbage(d);
            @(negedge clk);
            lat++;
        end
        garbage(d);
        check({tag, "_latency"}, 32'(lat), 32'(waits[d] + 1));
        check({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd1);
        check({tag, "_rsp_err"}, 32'(rsp_err[d]), 32'(e));
        if (known_rd) check({tag, "_rdata"}, rsp_rdata[d], exp_rd);
        rd0        = rsp_rdata[d];
        last_rdata = rd0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            garbage(d);
            check({tag, "_hold_valid"}, 32'(rsp_valid[d]), 32'd1);
            check({tag, "_hold_rdata"}, rsp_rdata[d], rd0);
            check({tag, "_hold_ready"}, 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        req_valid[d] = 1'b0;
        check({tag, "_done_valid"}, 32'(rsp_valid[d]), 32'd0);
        check({tag, "_done_ready"}, 32'(req_ready[d]), 32'd1);
        $display("txn %s dut%0d we=%0d addr=%08h wdata=%08h rdata=%08h err=%0d lat=%0d",
                 tag, d, we, a, wd, rd0, e, lat);
    endtask

    initial begin
        logic [31:0] a;
        int d;
        bit we;
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
            rsp_ready[i] = 1'b0;
`ifdef MEM_RESPONDER_BYTE_EN_EN
            req_wstrb[i] = 4'hF;
`endif
            for (int w = 0; w < NWORDS; w++) begin
                mdl[i][w]   = 32'd0;
                known[i][w] = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_req_ready", 32'(req_ready[i]), 32'd1);
            check("reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            check("reset_rsp_rdata", rsp_rdata[i], 32'd0);
            check("reset_rsp_err", 32'(rsp_err[i]), 32'd0);
        end

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "wr10");
        txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 0, "rd10");
        check("rd10_const", last_rdata, 32'hDEADBEEF);
        txn(0, 1'b1, 32'h24, 32'h12345678, 4'hF, 0, "wr24");
        txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 5, "backpressure");
        txn(0, 1'b0, 32'h24, 32'd0, 4'hF, 0, "rd24");
        check("rd24_const", last_rdata, 32'h12345678);
        txn(0, 1'b1, 32'h12, 32'h0BAD0BAD, 4'hF, 0, "wr_misaligned");
        txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 0, "rd10_after_err");
        check("rd10_after_err_const", last_rdata, 32'hDEADBEEF);
        txn(0, 1'b0, 32'h400, 32'd0, 4'hF, 0, "rd_oob");

        for (int i = 0; i < 4; i++)
            txn(1, 1'b1, 32'h40 + 32'(4 * i), $urandom, 4'hF, 0, "w0_fill");
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        rsp_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr[1] = 32'h40 + 32'(4 * i);
            check("b2b_idle_ready", 32'(req_ready[1]), 32'd1);
            @(negedge clk);
            check("b2b_rsp_valid", 32'(rsp_valid[1]), 32'd1);
            check("b2b_rdata", rsp_rdata[1], mdl[1][16 + i]);
            $display("txn b2b dut1 addr=%08h rdata=%08h", req_addr[1], rsp_rdata[1]);
            @(negedge clk);
            check("b2b_back_idle", 32'(rsp_valid[1]), 32'd0);
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b0;

        for (int i = 0; i < 40; i++) begin
            d  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            a  = 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'h400 << $urandom_range(0, 21));
            txn(d, we, a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), "rand");
        end

        // Reset in the middle of a read's wait states drops the read.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h10;
        @(negedge clk);
        req_valid[0] = 1'b0;
        reset_n      = 1'b0;
        #1;
        check("midreset_valid", 32'(rsp_valid[0]), 32'd0);
        check("midreset_ready", 32'(req_ready[0]), 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("postreset_valid", 32'(rsp_valid[0]), 32'd0);
            check("postreset_ready", 32'(req_ready[0]), 32'd1);
        end
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "rewr10");
        txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 0, "rd10_post_reset");
        check("rd10_post_reset_const", last_rdata, 32'hDEADBEEF);

`ifdef MEM_RESPONDER_BYTE_EN_EN
        txn(0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 0, "wr_strb");
        txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 0, "rd_strb");
        check("rd_strb_const", last_rdata, 32'hDEADAAEF);
        txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, "wr_nostrb");
        txn(0, 1'b1, 32'h11, 32'h0000CC00, 4'b0011, 0, "wr_strb_bad");
        txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 0, "rd_strb2");
        check("rd_strb2_const", last_rdata, 32'hDEADAAEF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
